// File: rtl/cmd_frame_ctrl.sv
// Byte-framed command controller: decodes UART RX commands, drives register file / ALU, and serialises responses into the TX FIFO.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module cmd_frame_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int OUT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_P_Data,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] Rd_D,
    input  logic                  RdData_Valid,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_Valid,
    input  logic                  FIFO_FULL,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEN,
    output logic                  RdEN,
    output logic [DATA_WIDTH-1:0] Wr_D,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  clk_gate_en,
    output logic                  clk_div_en,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  cmd_error
);

    localparam int SH_W     = (DATA_WIDTH > OUT_WIDTH) ? DATA_WIDTH : OUT_WIDTH;
    localparam int SH_BYTES = SH_W / 8;
    localparam int CNT_W    = $clog2(SH_BYTES + 1);

    localparam logic [7:0] OP_WR     = 8'hAA;
    localparam logic [7:0] OP_RD     = 8'hBB;
    localparam logic [7:0] OP_ALU_OP = 8'hCC;
    localparam logic [7:0] OP_ALU_NO = 8'hDD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_ALU_A,
        S_ALU_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_SEND
    } state_t;

    state_t           r_state;
    logic [SH_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_tx_left;
    logic             w_addr_ok;
    logic             w_timeout;

    // Any address bit above ADDR_WIDTH marks the byte as out of range
    assign w_addr_ok = ((RX_P_Data >> ADDR_WIDTH) == 8'd0);

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_operand;

    assign w_operand = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) ||
                       (r_state == S_RD_ADDR) || (r_state == S_ALU_A)   ||
                       (r_state == S_ALU_B)   || (r_state == S_ALU_FUN);
    assign w_timeout = w_operand && !RX_D_VLD &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Every operand-state entry happens on an RX byte, so clearing on RX_D_VLD covers entry too
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_to_cnt <= '0;
        end else if (RX_D_VLD || !w_operand) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_tx_left   <= '0;
            Address     <= '0;
            WrEN        <= 1'b0;
            RdEN        <= 1'b0;
            Wr_D        <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= 4'd0;
            clk_gate_en <= 1'b0;
            clk_div_en  <= 1'b0;
            TX_P_DATA   <= 8'd0;
            TX_D_VLD    <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            clk_div_en <= 1'b1;
            WrEN       <= 1'b0;
            RdEN       <= 1'b0;
            TX_D_VLD   <= 1'b0;
            cmd_error  <= 1'b0;

            if (w_timeout) begin
                cmd_error <= 1'b1;
                r_state   <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (RX_D_VLD) begin
                            case (RX_P_Data)
                                OP_WR:     r_state <= S_WR_ADDR;
                                OP_RD:     r_state <= S_RD_ADDR;
                                OP_ALU_OP: r_state <= S_ALU_A;
                                OP_ALU_NO: r_state <= S_ALU_FUN;
                                default:   cmd_error <= 1'b1;
                            endcase
                        end
                    end

                    S_WR_ADDR: begin
                        if (RX_D_VLD) begin
                            if (w_addr_ok) begin
                                Address <= RX_P_Data[ADDR_WIDTH-1:0];
                                r_state <= S_WR_DATA;
                            end else begin
                                cmd_error <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end
                    end

                    S_WR_DATA: begin
                        if (RX_D_VLD) begin
                            WrEN    <= 1'b1;
                            Wr_D    <= DATA_WIDTH'(RX_P_Data);
                            r_state <= S_IDLE;
                        end
                    end

                    S_RD_ADDR: begin
                        if (RX_D_VLD) begin
                            if (w_addr_ok) begin
                                Address <= RX_P_Data[ADDR_WIDTH-1:0];
                                RdEN    <= 1'b1;
                                r_state <= S_RD_WAIT;
                            end else begin
                                cmd_error <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end
                    end

                    S_RD_WAIT: begin
                        if (RX_D_VLD) begin
                            cmd_error <= 1'b1;
                        end
                        if (RdData_Valid) begin
                            r_shift   <= SH_W'(Rd_D);
                            r_tx_left <= CNT_W'(DATA_WIDTH / 8);
                            r_state   <= S_TX_SEND;
                        end
                    end

                    S_ALU_A: begin
                        if (RX_D_VLD) begin
                            Address <= '0;
                            Wr_D    <= DATA_WIDTH'(RX_P_Data);
                            WrEN    <= 1'b1;
                            r_state <= S_ALU_B;
                        end
                    end

                    S_ALU_B: begin
                        if (RX_D_VLD) begin
                            Address <= ADDR_WIDTH'(1);
                            Wr_D    <= DATA_WIDTH'(RX_P_Data);
                            WrEN    <= 1'b1;
                            r_state <= S_ALU_FUN;
                        end
                    end

                    S_ALU_FUN: begin
                        if (RX_D_VLD) begin
                            ALU_FUN     <= RX_P_Data[3:0];
                            ALU_EN      <= 1'b1;
                            clk_gate_en <= 1'b1;
                            r_state     <= S_ALU_WAIT;
                        end
                    end

                    S_ALU_WAIT: begin
                        if (RX_D_VLD) begin
                            cmd_error <= 1'b1;
                        end
                        if (OUT_Valid) begin
                            r_shift     <= SH_W'(ALU_OUT);
                            r_tx_left   <= CNT_W'(OUT_WIDTH / 8);
                            ALU_EN      <= 1'b0;
                            clk_gate_en <= 1'b0;
                            r_state     <= S_TX_SEND;
                        end
                    end

                    S_TX_SEND: begin
                        if (RX_D_VLD) begin
                            cmd_error <= 1'b1;
                        end
                        // A full FIFO holds the current byte and index in place
                        if (!FIFO_FULL) begin
                            TX_D_VLD  <= 1'b1;
                            TX_P_DATA <= r_shift[7:0];
                            r_shift   <= r_shift >> 8;
                            r_tx_left <= r_tx_left - 1'b1;
                            if (r_tx_left == CNT_W'(1)) begin
                                r_state <= S_IDLE;
                            end
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/cmd_frame_ctrl.md
Name: cmd_frame_ctrl

Overview:
- Generalised successor to the system controller. Parses byte-framed commands from the synchronised UART RX path and drives the register file and ALU.
- Serialises multi-byte responses (read data, ALU result of any byte-multiple width) into the async TX FIFO, with FIFO_FULL back-pressure.
- Adds address-range checking, an error pulse, and an optional inter-byte timeout.
- Sits in the REF clock domain between the data synchroniser, register file, ALU/clock gate and the write side of the async FIFO.

Parameters:
- DATA_WIDTH, 8: register-file data width; multiple of 8.
- ADDR_WIDTH, 4: register-file address width; ≤ 8.
- OUT_WIDTH, 16: ALU result width; multiple of 8.
- TIMEOUT_CYCLES, 4096: inter-byte timeout in CLK cycles (used only with CMD_TIMEOUT_EN).

Ports:
- CLK  in  1  REF-domain clock
- RST  in  1  reset, asynchronous, active-low
- RX_P_Data  in  8  synchronised RX byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_Data valid
- Rd_D  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  read data valid
- ALU_OUT  in  OUT_WIDTH  ALU result
- OUT_Valid  in  1  ALU result valid
- FIFO_FULL  in  1  TX FIFO full
- Address  out  ADDR_WIDTH  register-file address
- WrEN  out  1  register write strobe
- RdEN  out  1  register read strobe
- Wr_D  out  DATA_WIDTH  register write data
- ALU_EN  out  1  ALU enable
- ALU_FUN  out  4  ALU function
- clk_gate_en  out  1  ALU clock-gate enable
- clk_div_en  out  1  UART clock-divider enable
- TX_P_DATA  out  8  byte pushed to FIFO
- TX_D_VLD  out  1  FIFO write strobe
- cmd_error  out  1  one-cycle error pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE. clk_div_en goes to 1 on the first CLK edge after RST deasserts and stays 1.
- Opcodes, decoded in IDLE on RX_D_VLD:
  - 0xAA: register write
  - 0xBB: register read
  - 0xCC: ALU with operands
  - 0xDD: ALU without operands
  - Any other value: cmd_error pulse next cycle, stay in IDLE.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_SEND.
- Address byte (WR_ADDR, RD_ADDR):
  - Address = byte[ADDR_WIDTH-1:0].
  - If byte[7:ADDR_WIDTH] ≠ 0: cmd_error pulse, return to IDLE, no strobe issued.
- Write path (0xAA): WR_ADDR → WR_DATA. On the data byte, WrEN=1 for exactly one cycle with Wr_D=byte; then IDLE.
- Read path (0xBB): on a valid address, RdEN=1 for one cycle, go to RD_WAIT. On RdData_Valid, latch Rd_D into the response shift register (DATA_WIDTH/8 bytes), go to TX_SEND.
- ALU with operands (0xCC): ALU_A → ALU_B → ALU_FUN.
  - A byte: write to Address 0 (one-cycle WrEN).
  - B byte: write to Address 1 (one-cycle WrEN).
  - FUN byte: ALU_FUN=byte[3:0]; ALU_EN=1 and clk_gate_en=1 from the next cycle until OUT_Valid is sampled.
- ALU without operands (0xDD): go directly to ALU_FUN.
- ALU_WAIT: on OUT_Valid, latch ALU_OUT (OUT_WIDTH/8 bytes), drop ALU_EN and clk_gate_en in the same cycle, go to TX_SEND.
- TX_SEND:
  - Bytes sent LSB first. One byte per cycle with TX_D_VLD=1 only when FIFO_FULL=0.
  - When FIFO_FULL=1: TX_D_VLD=0, the byte is held, and the byte index does not advance.
  - After the last byte, return to IDLE.
  - Minimum latency from the strobe to the first TX_D_VLD: 1 cycle.
- RX_D_VLD while in RD_WAIT, ALU_WAIT or TX_SEND: byte dropped, cmd_error pulse, state unchanged.
- ALU_FUN and Address hold their last values between commands.
- Asynchronous reset mid-frame or mid-TX_SEND: immediate return to the reset state; the partial response is discarded.

Optional Feature:
- CMD_TIMEOUT_EN defined:
  - A counter clears on every RX_D_VLD and on entry to any operand state (WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN).
  - If the counter reaches TIMEOUT_CYCLES in an operand state: cmd_error pulse, go to IDLE, no WrEN/RdEN/ALU_EN issued.
  - The counter does not run in RD_WAIT, ALU_WAIT or TX_SEND.
- CMD_TIMEOUT_EN undefined: operand states wait indefinitely; no counter logic is present.

Test Plan:
- Bytes AA,05,3C → one-cycle WrEN with Address=5, Wr_D=0x3C; no TX_D_VLD; cmd_error stays 0.
- Bytes BB,05, then RdData_Valid with Rd_D=0x3C → one RdEN with Address=5, then exactly one TX_D_VLD with TX_P_DATA=0x3C.
- Bytes CC,0A,14,00, then OUT_Valid with ALU_OUT=0x001E → WrEN to addr 0 (0x0A) and addr 1 (0x14); ALU_EN and clk_gate_en high until OUT_Valid; TX bytes 0x1E then 0x00.
- Bytes DD,02 with FIFO_FULL held high for 5 cycles during TX_SEND, ALU_OUT=0xBEEF → no TX_D_VLD while full; then 0xEF, 0xBE each strobed once.
- Byte 0x55, then AA,20 (ADDR_WIDTH=4) → two cmd_error pulses; no WrEN; FSM in IDLE.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: bytes AA,03, then silence for 16 cycles → cmd_error pulse, IDLE; a following byte 0x77 gives cmd_error (unknown opcode).
